// File: rtl/stopwatch_timer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_timer_ctrl_pkg
// Shared definitions for the mm:ss stopwatch/timer controller:
//   - state codes (IDLE/RUN/PAUSE/DONE), also driven onto the debug LEDs
//   - mode codes for the up/down switch
//   - BCD limits for a 00..59 two-digit field
//   - single-field BCD increment/decrement helpers with carry/borrow out
// ---------------------------------------------------------------------------
package stopwatch_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    localparam logic [7:0] BCD_MAX = 8'h59;
    localparam logic [7:0] BCD_MIN = 8'h00;

    // Result of stepping one 00..59 BCD field: new value plus carry/borrow
    // into the next field.
    typedef struct packed {
        logic       carry;
        logic [7:0] val;
    } bcd_step_t;

    // 59 -> 00 with carry; ones digit 9 rolls into the tens digit.
    function automatic bcd_step_t bcd59_inc(input logic [7:0] v);
        bcd_step_t r;
        r.carry = 1'b0;
        if (v == BCD_MAX) begin
            r.carry = 1'b1;
            r.val   = BCD_MIN;
        end else if (v[3:0] == 4'd9) begin
            r.val = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r.val = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // 00 -> 59 with borrow; ones digit 0 borrows from the tens digit.
    function automatic bcd_step_t bcd59_dec(input logic [7:0] v);
        bcd_step_t r;
        r.carry = 1'b0;
        if (v == BCD_MIN) begin
            r.carry = 1'b1;
            r.val   = BCD_MAX;
        end else if (v[3:0] == 4'd0) begin
            r.val = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r.val = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_timer_ctrl_bcd_mmss_counter.sv
// ---------------------------------------------------------------------------
// bcd_mmss_counter
// Two-field BCD mm:ss counter, each field 00..59. Load has priority over step.
// Ports:
//   clk_100            system clock
//   rst_n              async active-low reset (loads load_min/load_sec)
//   load               synchronous load of load_min:load_sec
//   load_min/load_sec  BCD value to load (also the reset value)
//   step               advance by one second
//   up                 1 = count up, 0 = count down
//   min/sec            current BCD value
//   zero               high when the counter reads 00:00
// ---------------------------------------------------------------------------
module bcd_mmss_counter
    import stopwatch_timer_ctrl_pkg::*;
(
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    input  logic       step,
    input  logic       up,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       zero
);

    logic [7:0] min_d, min_q;
    logic [7:0] sec_d, sec_q;
    bcd_step_t  sec_inc, sec_dec, min_inc, min_dec;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        min_d   = min_q;
        sec_d   = sec_q;
        sec_inc = bcd59_inc(sec_q);
        sec_dec = bcd59_dec(sec_q);
        min_inc = bcd59_inc(min_q);
        min_dec = bcd59_dec(min_q);
        if (load) begin
            min_d = load_min;
            sec_d = load_sec;
        end else if (step) begin
            if (up) begin
                sec_d = sec_inc.val;
                if (sec_inc.carry) min_d = min_inc.val;   // 59:59 wraps to 00:00
            end else begin
                sec_d = sec_dec.val;
                if (sec_dec.carry) min_d = min_dec.val;
            end
        end
    end

    // The reset value follows the load inputs so the display shows the
    // current mode's start value while reset is held, without a clock.
    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= load_min;
            sec_q <= load_sec;
        end else begin
            min_q <= min_d;
            sec_q <= sec_d;
        end
    end

    assign min  = min_q;
    assign sec  = sec_q;
    assign zero = (min_q == BCD_MIN) && (sec_q == BCD_MIN);

endmodule

// File: rtl/stopwatch_timer_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_timer_ctrl
// Mode sequencer for the mm:ss stopwatch/timer: IDLE/RUN/PAUSE/DONE FSM, lap
// freeze register and display select, driving a bcd_mmss_counter.
// Ports:
//   clk_100             system clock
//   rst_n               async active-low reset
//   de_start_stop       one-cycle pulse, start/stop button
//   de_s_min_lap_reset  one-cycle pulse, lap/reset button
//   count_up_down       0 = count up from 00:00, 1 = count down from preset
//   tick_1hz            one-cycle pulse per second
//   count_enable        high while in RUN
//   lap_enable          high while the lap freeze is active
//   alarm               high while in DONE
//   state_o             state code for debug LEDs
//   disp_min/disp_sec   BCD value for the 7-segment scan driver
// ---------------------------------------------------------------------------
module stopwatch_timer_ctrl
    import stopwatch_timer_ctrl_pkg::*;
#(
    parameter logic [7:0] PRESET_MIN = 8'h01,
    parameter logic [7:0] PRESET_SEC = 8'h30
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic       de_start_stop,
    input  logic       de_s_min_lap_reset,
    input  logic       count_up_down,
    input  logic       tick_1hz,
    output logic       count_enable,
    output logic       lap_enable,
    output logic       alarm,
    output logic [1:0] state_o,
    output logic [7:0] disp_min,
    output logic [7:0] disp_sec
);

    state_e     state_d, state_q;
    logic       lap_d, lap_q;
    logic [7:0] lap_min_d, lap_min_q;
    logic [7:0] lap_sec_d, lap_sec_q;
    logic       mode_q;
    logic       count_enable_q, alarm_q;

    logic       load, step;
    logic [7:0] start_min, start_sec;
    logic [7:0] cnt_min, cnt_sec;
    logic       cnt_zero, cnt_one;
    logic       mode_change, up_mode;

    // Start value taken from the live switch: on a mode change it is the new
    // mode's value; otherwise the switch equals mode_q anyway.
    assign start_min   = (count_up_down == MODE_DOWN) ? PRESET_MIN : BCD_MIN;
    assign start_sec   = (count_up_down == MODE_DOWN) ? PRESET_SEC : BCD_MIN;
    assign mode_change = (count_up_down != mode_q);
    assign up_mode     = (mode_q == MODE_UP);
    assign cnt_one     = (cnt_min == BCD_MIN) && (cnt_sec == 8'h01);

    bcd_mmss_counter u_counter (
        .clk_100  (clk_100),
        .rst_n    (rst_n),
        .load     (load),
        .load_min (start_min),
        .load_sec (start_sec),
        .step     (step),
        .up       (up_mode),
        .min      (cnt_min),
        .sec      (cnt_sec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        lap_d     = lap_q;
        lap_min_d = lap_min_q;
        lap_sec_d = lap_sec_q;
        load      = 1'b0;
        step      = 1'b0;

        if (mode_change) begin
            state_d = IDLE;
            lap_d   = 1'b0;
            load    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (de_start_stop) begin
                        state_d = RUN;
                    end else if (de_s_min_lap_reset) begin
                        load = 1'b1;
                    end
                end
                RUN: begin
                    if (de_start_stop) begin
                        state_d = PAUSE;
                    end else if (de_s_min_lap_reset) begin
                        lap_d = !lap_q;
                        if (!lap_q) begin
                            lap_min_d = cnt_min;     // pre-tick snapshot
                            lap_sec_d = cnt_sec;
                        end
                    end
                    // Reaching 00:00 in count-down beats a concurrent stop.
                    if (tick_1hz) begin
                        if (!up_mode && cnt_zero) begin
                            state_d = DONE;
                        end else begin
                            step = 1'b1;
                            if (!up_mode && cnt_one) state_d = DONE;
                        end
                    end
                    if (state_d == DONE) lap_d = 1'b0;
                end
                PAUSE: begin
                    if (de_start_stop) begin
                        state_d = RUN;
                    end else if (de_s_min_lap_reset) begin
                        if (lap_q) begin
                            lap_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                            load    = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (de_start_stop || de_s_min_lap_reset) begin
                        state_d = IDLE;
                        load    = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // mode_q resets to MODE_UP: if the switch is down at reset, the first
    // clock sees a mode change that reloads the preset and stays in IDLE,
    // which matches the state reset already produced.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            lap_q          <= 1'b0;
            lap_min_q      <= 8'h00;
            lap_sec_q      <= 8'h00;
            mode_q         <= MODE_UP;
            count_enable_q <= 1'b0;
            alarm_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            lap_q          <= lap_d;
            lap_min_q      <= lap_min_d;
            lap_sec_q      <= lap_sec_d;
            mode_q         <= count_up_down;
            count_enable_q <= (state_d == RUN);
            alarm_q        <= (state_d == DONE);
        end
    end

    assign count_enable = count_enable_q;
    assign alarm        = alarm_q;
    assign lap_enable   = lap_q;
    assign state_o      = state_q;
    assign disp_min     = lap_q ? lap_min_q : cnt_min;
    assign disp_sec     = lap_q ? lap_sec_q : cnt_sec;

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_timer_ctrl
// Directed stimulus pushes hand-computed expected outputs into a queue; a
// monitor on the falling clock edge pops and compares them against the DUT.
// Expected word: {state_o, count_enable, lap_enable, alarm, disp_min, disp_sec}
// ---------------------------------------------------------------------------
module tb_stopwatch_timer_ctrl;

    logic       clk_100 = 1'b0;
    logic       rst_n   = 1'b0;
    logic       de_start_stop      = 1'b0;
    logic       de_s_min_lap_reset = 1'b0;
    logic       count_up_down      = 1'b0;
    logic       tick_1hz           = 1'b0;
    logic       count_enable, lap_enable, alarm;
    logic [1:0] state_o;
    logic [7:0] disp_min, disp_sec;

    logic [20:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk_100 = ~clk_100;

    stopwatch_timer_ctrl dut (
        .clk_100            (clk_100),
        .rst_n              (rst_n),
        .de_start_stop      (de_start_stop),
        .de_s_min_lap_reset (de_s_min_lap_reset),
        .count_up_down      (count_up_down),
        .tick_1hz           (tick_1hz),
        .count_enable       (count_enable),
        .lap_enable         (lap_enable),
        .alarm              (alarm),
        .state_o            (state_o),
        .disp_min           (disp_min),
        .disp_sec           (disp_sec)
    );

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got st=%0d ce=%b lap=%b al=%b %h:%h, expected st=%0d ce=%b lap=%b al=%b %h:%h",
                      name, act[20:19], act[18], act[17], act[16], act[15:8], act[7:0],
                      exp[20:19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
    endtask

    // Monitor: compares every pending expectation on the falling edge.
    always @(negedge clk_100) begin
        while (exp_q.size() > 0) begin
            check(name_q.pop_front(),
                  {state_o, count_enable, lap_enable, alarm, disp_min, disp_sec},
                  exp_q.pop_front());
        end
    end

    task automatic expect_out(input string name, input logic [1:0] st, input logic ce,
                              input logic lp, input logic al, input logic [7:0] m, input logic [7:0] s);
        exp_q.push_back({st, ce, lp, al, m, s});
        name_q.push_back(name);
    endtask

    // One clock with the given pulses; pulses drop 1 ns after the edge.
    task automatic cyc(input logic st, input logic lp, input logic tk);
        de_start_stop      = st;
        de_s_min_lap_reset = lp;
        tick_1hz           = tk;
        @(posedge clk_100);
        #1;
        de_start_stop      = 1'b0;
        de_s_min_lap_reset = 1'b0;
        tick_1hz           = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    // Assert reset between edges, expect outputs without any rising edge,
    // then release after the monitor has sampled.
    task automatic reset_check(input string name, input logic [7:0] m, input logic [7:0] s);
        rst_n = 1'b0;
        #1;
        expect_out(name, 2'd0, 1'b0, 1'b0, 1'b0, m, s);
        @(negedge clk_100);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Up mode: reset, run 65 s, pause ignores ticks
        repeat (3) @(posedge clk_100);
        #1;
        reset_check("reset_up", 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0);
        expect_out("start_up", 2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        ticks(65);
        expect_out("run_65", 2'd1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h05);
        cyc(1'b1, 1'b0, 1'b0);
        ticks(3);
        expect_out("pause_hold", 2'd2, 1'b0, 1'b0, 1'b0, 8'h01, 8'h05);
        cyc(1'b0, 1'b1, 1'b0);
        expect_out("pause_reset", 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Up-mode wrap at 59:59
        cyc(1'b1, 1'b0, 1'b0);
        ticks(3598);
        expect_out("run_5958", 2'd1, 1'b1, 1'b0, 1'b0, 8'h59, 8'h58);
        ticks(1);
        expect_out("run_5959", 2'd1, 1'b1, 1'b0, 1'b0, 8'h59, 8'h59);
        ticks(1);
        expect_out("wrap_0000", 2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

        // Lap freeze while running
        ticks(10);
        expect_out("run_0010", 2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10);
        cyc(1'b0, 1'b1, 1'b0);
        expect_out("lap_set", 2'd1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h10);
        ticks(5);
        expect_out("lap_frozen", 2'd1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h10);
        cyc(1'b0, 1'b1, 1'b0);
        expect_out("lap_clear", 2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h15);
        cyc(1'b1, 1'b0, 1'b0);
        expect_out("pause_0015", 2'd2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h15);
        cyc(1'b0, 1'b1, 1'b0);
        expect_out("pause_reset2", 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Lap with concurrent tick captures pre-tick value; lap in PAUSE clears lap only
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        expect_out("lap_pretick", 2'd1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0);
        expect_out("pause_lap_held", 2'd2, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b0);
        expect_out("pause_lap_clr", 2'd2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01);

        // Start+lap same cycle; tick+start same cycle
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        expect_out("start_lap_same", 2'd2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        expect_out("tick_start_same", 2'd2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02);

        // Switch to down mode while paused, then reset with the switch down
        count_up_down = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        expect_out("mode_to_down", 2'd0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h30);
        reset_check("reset_down", 8'h01, 8'h30);
        cyc(1'b0, 1'b0, 1'b0);
        expect_out("idle_down", 2'd0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h30);

        // Count down 90 s to DONE
        cyc(1'b1, 1'b0, 1'b0);
        ticks(89);
        expect_out("down_0001", 2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01);
        ticks(1);
        expect_out("down_done", 2'd3, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        ticks(2);
        expect_out("done_hold", 2'd3, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0);
        expect_out("done_exit", 2'd0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h30);

        // Mode toggle mid-RUN overrides buttons
        count_up_down = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        expect_out("mode_to_up", 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0);
        ticks(20);
        expect_out("up_0020", 2'd1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h20);
        count_up_down = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        expect_out("mode_mid_run", 2'd0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h30);

        // Async reset mid-RUN in down mode
        cyc(1'b1, 1'b0, 1'b0);
        ticks(2);
        expect_out("down_0128", 2'd1, 1'b1, 1'b0, 1'b0, 8'h01, 8'h28);
        @(posedge clk_100);
        #1;
        reset_check("reset_mid_run", 8'h01, 8'h30);

        repeat (2) @(posedge clk_100);
        @(negedge clk_100);
        #1;
        while (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL %s: got no sample, expected a compare", name_q.pop_front());
            void'(exp_q.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_timer_ctrl.md
Name: stopwatch_timer_ctrl

Overview:
Mode sequencer for the lab 7 mm:ss stopwatch/timer datapath. Takes debounced one-pulse buttons and the up/down mode switch, and runs a BCD minute:second counter through idle/run/pause/done. Also handles lap freeze, pause-reset and count-down alarm, and selects the value shown on the 7-segment scan driver. Sits between the debounce/one-pulse blocks and the display decoder.

Parameters:
PRESET_MIN, 8'h01, BCD minutes loaded in count-down mode (01).
PRESET_SEC, 8'h30, BCD seconds loaded in count-down mode (30).

Ports:
clk_100  input  1  system clock. One clock domain; all state changes on the rising edge.
rst_n  input  1  reset. Asynchronous, active-low.
de_start_stop  input  1  debounced one-cycle pulse, start/stop button.
de_s_min_lap_reset  input  1  debounced one-cycle pulse, lap/reset button.
count_up_down  input  1  mode level: 0 = count up from 00:00; 1 = count down from preset.
tick_1hz  input  1  one-cycle pulse once per second.
count_enable  output  1  high while in RUN.
lap_enable  output  1  high while the lap freeze is active.
alarm  output  1  high while in DONE.
state_o  output  2  current state code, for debug LEDs.
disp_min  output  8  two BCD digits of minutes shown on the display.
disp_sec  output  8  two BCD digits of seconds shown on the display.

Behaviour:
- States: IDLE=0, RUN=1, PAUSE=2, DONE=3. The state is held in a register; every output is decoded from registers.
- Reset (rst_n low, asynchronous): state=IDLE, lap=0, lap_reg=0, counter=00:00 if count_up_down=0 else preset. Outputs count_enable=0, lap_enable=0, alarm=0.
- Latency: a pulse sampled at edge n changes the state at edge n; the outputs reflect it in the following cycle.
- Mode change: count_up_down is registered. If the registered value differs from the input, next state=IDLE, lap=0, and the counter is reloaded with the new mode's start value. This overrides all buttons in that cycle.
- Priority in one cycle: mode change > de_start_stop > de_s_min_lap_reset. Lap is ignored whenever start is present.
- IDLE: start goes to RUN. lap_reset reloads the start value and stays in IDLE.
- RUN:
  - tick_1hz steps the counter: +1 s in up mode, -1 s in down mode.
  - start goes to PAUSE. A tick in the same cycle is still applied.
  - lap_reset toggles lap. When lap sets, lap_reg captures the pre-tick counter value of that cycle. The counter keeps running while lap is set.
- PAUSE:
  - Counter holds; ticks are ignored.
  - start goes to RUN.
  - lap_reset with lap=1 clears lap only.
  - lap_reset with lap=0 reloads the start value and goes to IDLE.
- DONE: counter holds at 00:00 and alarm=1. start or lap_reset reloads the preset, goes to IDLE and clears alarm.
- Up-mode wrap: a tick at 59:59 gives 00:00 and counting continues.
- Down-mode terminal: a tick at 00:01 gives 00:00 and the next state is DONE. A tick at 00:00 in RUN (preset 00:00) goes straight to DONE without decrementing.
- BCD rules:
  - Seconds ones 9→0 carry into seconds tens; tens 5→0 carry into minutes.
  - Borrow is the mirror: seconds 00→59, borrowing from minutes.
  - Minutes 00–59.
  - A digit value >9 never appears.
- Display: disp = lap_reg when lap=1, else the live counter.
- Leaving RUN/PAUSE to IDLE or DONE always clears lap.

Decomposition:
- Shared header lab7_defs.vh holds:
  - the state codes IDLE/RUN/PAUSE/DONE;
  - the mode codes MODE_UP=0 and MODE_DOWN=1;
  - the BCD limits 8'h59 and 8'h00.
- One sub-module, bcd_mmss_counter. Inputs: clk_100, rst_n, load, load_min, load_sec, step, up. Outputs: min and sec BCD registers, and zero (asserted at 00:00).
- The FSM, lap register and display mux stay in stopwatch_timer_ctrl.

Test Plan:
- Up mode, reset, start, 65 ticks → disp 01:05, count_enable=1. Start then 3 ticks → disp stays 01:05, state_o=2.
- Up mode, preload 59:58, run, 2 ticks → 59:59 then 00:00, state stays RUN.
- Up mode RUN at 00:10: lap (lap_enable=1, disp frozen 00:10) → 5 ticks, disp 00:10 → lap again, disp 00:15. Then pause and lap_reset → 00:00, IDLE.
- Down mode, defaults: reset → disp 01:30. Start, 90 ticks → 00:00, alarm=1, state_o=3. Start → 01:30, IDLE, alarm=0.
- Same cycle start+lap in RUN → PAUSE, lap_enable stays 0. Same cycle tick+start → count advanced by 1, then PAUSE.
- Toggle count_up_down mid-RUN at 00:20 → next cycle IDLE, disp 01:30. rst_n low mid-RUN → immediate IDLE, outputs 0, no clock needed.
